// File: rtl/bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// bus_req_arbiter
//
// N-channel front end for the bus controller's internal request port. Several
// requesters (instruction cache, data cache, prefetch, DMA) share one
// controller. A winner is picked in IDLE by round-robin or fixed priority. Its
// address, size, direction and write data are latched onto the bus_* outputs.
// The controller then sees a single bus_req pulse. The controller's
// completion, read data and bus error are returned to the winner with a
// one-cycle ch_done strobe. A watchdog forces an error completion if the
// controller never terminates the cycle.
//
// Handshakes:
//   requester side: a channel raises ch_req[k] (a level) with its addr, size,
//     rnw and wdata stable. It keeps all of them until ch_done[k] pulses for
//     one cycle, and drops ch_req[k] on the edge that ends that cycle.
//     ch_rdata and ch_err are valid while ch_done is high and hold afterwards.
//   controller side: bus_req pulses for one cycle with bus_addr, bus_size,
//     bus_rnw and bus_wdata valid. Those fields stay stable until the
//     transaction ends. bus_complete is accepted only in WAIT, and bus_rdata
//     and bus_berr are sampled in that same cycle.
//
// Ports:
//   CLK, nRESET     clock (rising edge), asynchronous active-low reset
//   ch_req          per-channel request level
//   ch_addr         per-channel address, channel k at [k*AW +: AW]
//   ch_size         per-channel size (00 long, 01 byte, 10 word, 11 3-byte)
//   ch_rnw          per-channel direction, 1 = read
//   ch_wdata        per-channel write data, channel k at [k*DW +: DW]
//   ch_done         one-hot completion strobe
//   ch_err          error flag, valid with ch_done
//   ch_rdata        read data, valid with ch_done (0 for writes and timeouts)
//   grant           one-hot owner of the current transaction, 0 when idle
//   busy            high in every state except IDLE
//   bus_req         one-cycle request pulse to the controller
//   bus_addr/size/rnw/wdata  latched transaction fields
//   bus_complete    controller completion (level or pulse)
//   bus_rdata       controller read data
//   bus_berr        controller bus error
//   dbg_state       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
// -----------------------------------------------------------------------------
module bus_req_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 256
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*2-1:0]  ch_size,
    input  logic [NUM_CH-1:0]    ch_rnw,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 ch_err,
    output logic [DW-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]    grant,
    output logic                 busy,
    output logic                 bus_req,
    output logic [AW-1:0]        bus_addr,
    output logic [1:0]           bus_size,
    output logic                 bus_rnw,
    output logic [DW-1:0]        bus_wdata,
    input  logic                 bus_complete,
    input  logic [DW-1:0]        bus_rdata,
    input  logic                 bus_berr,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // The counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              state;
    state_t              state_nx;
    logic [IW-1:0]       ptr;
    logic [CW-1:0]       cnt;
    logic                tmo_hit;

    // Arbitration results, meaningful only while in IDLE.
    logic                found;
    logic [IW-1:0]       win_idx;
    logic [NUM_CH-1:0]   win_oh;
    logic [NUM_CH-1:0]   rr_mask;
    logic [NUM_CH-1:0]   hi_req;
    logic [NUM_CH-1:0]   pick_src;
    logic [AW-1:0]       win_addr;
    logic [1:0]          win_size;
    logic                win_rnw;
    logic [DW-1:0]       win_wdata;

    // ------------------------------------------------------------------
    // Winner selection. Round-robin is done as a masked priority pick:
    // requests strictly above ptr are tried first (lowest index wins).
    // If none are pending there, the search wraps to the full request
    // vector. Fixed priority is the same pick without the mask.
    // ------------------------------------------------------------------
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_mask[i] = (i > int'(ptr));
        end
        hi_req   = ch_req & rr_mask;
        pick_src = ((RR_MODE != 0) && (hi_req != '0)) ? hi_req : ch_req;

        found   = |ch_req;
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                win_idx    = IW'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_size  = '0;
        win_rnw   = 1'b1;
        win_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == int'(win_idx)) begin
                win_addr  = ch_addr[i*AW +: AW];
                win_size  = ch_size[i*2 +: 2];
                win_rnw   = ch_rnw[i];
                win_wdata = ch_wdata[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmo_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                // The controller cannot legally finish in the request cycle.
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus_complete) begin
                    state_nx = S_RESP;
                end else if (TMO_EN && (cnt == TMO_LAST)) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ptr       <= IW'(NUM_CH - 1);
            cnt       <= '0;
            grant     <= '0;
            bus_addr  <= '0;
            bus_size  <= '0;
            bus_rnw   <= 1'b1;
            bus_wdata <= '0;
            ch_rdata  <= '0;
            ch_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant     <= win_oh;
                        bus_addr  <= win_addr;
                        bus_size  <= win_size;
                        bus_rnw   <= win_rnw;
                        bus_wdata <= win_wdata;
                        if (RR_MODE != 0) begin
                            ptr <= win_idx;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    if (bus_complete) begin
                        ch_rdata <= bus_rnw ? bus_rdata : '0;
                        ch_err   <= bus_berr;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (tmo_hit) begin
                            ch_rdata <= '0;
                            ch_err   <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    grant <= '0;
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    assign bus_req   = (state == S_REQ);
    assign busy      = (state != S_IDLE);
    assign ch_done   = (state == S_RESP) ? grant : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_req_arbiter
//
// Two 4-channel instances share the channel payload and controller inputs.
// u_rr is round-robin and u_fp is fixed priority, both with a 16-cycle
// watchdog. sel_fp routes the request vector to one of them and picks which
// one the monitor signals (m_*) observe. The other instance sits in IDLE with
// no requests.
// -----------------------------------------------------------------------------
module tb_bus_req_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;

    // ---------------- clock / reset ----------------
    logic CLK    = 1'b0;
    logic nRESET = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- stimulus ----------------
    logic               sel_fp       = 1'b0;
    logic [NCH-1:0]     req          = '0;
    logic [NCH*AW-1:0]  ch_addr      = '0;
    logic [NCH*2-1:0]   ch_size      = '0;
    logic [NCH-1:0]     ch_rnw       = '1;
    logic [NCH*DW-1:0]  ch_wdata     = '0;
    logic               bus_complete = 1'b0;
    logic [DW-1:0]      bus_rdata    = '0;
    logic               bus_berr     = 1'b0;

    logic [NCH-1:0]     r_req, f_req;
    assign r_req = sel_fp ? '0 : req;
    assign f_req = sel_fp ? req : '0;

    // ---------------- DUT outputs ----------------
    logic [NCH-1:0] r_done, f_done, r_grant, f_grant;
    logic           r_err, f_err, r_busy, f_busy, r_bus_req, f_bus_req, r_bus_rnw, f_bus_rnw;
    logic [DW-1:0]  r_rdata, f_rdata, r_bus_wdata, f_bus_wdata;
    logic [AW-1:0]  r_bus_addr, f_bus_addr;
    logic [1:0]     r_bus_size, f_bus_size, r_state, f_state;

    bus_req_arbiter #(.NUM_CH(NCH), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
        .CLK(CLK), .nRESET(nRESET), .ch_req(r_req), .ch_addr(ch_addr), .ch_size(ch_size),
        .ch_rnw(ch_rnw), .ch_wdata(ch_wdata), .ch_done(r_done), .ch_err(r_err),
        .ch_rdata(r_rdata), .grant(r_grant), .busy(r_busy), .bus_req(r_bus_req),
        .bus_addr(r_bus_addr), .bus_size(r_bus_size), .bus_rnw(r_bus_rnw),
        .bus_wdata(r_bus_wdata), .bus_complete(bus_complete), .bus_rdata(bus_rdata),
        .bus_berr(bus_berr), .dbg_state(r_state)
    );

    bus_req_arbiter #(.NUM_CH(NCH), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fp (
        .CLK(CLK), .nRESET(nRESET), .ch_req(f_req), .ch_addr(ch_addr), .ch_size(ch_size),
        .ch_rnw(ch_rnw), .ch_wdata(ch_wdata), .ch_done(f_done), .ch_err(f_err),
        .ch_rdata(f_rdata), .grant(f_grant), .busy(f_busy), .bus_req(f_bus_req),
        .bus_addr(f_bus_addr), .bus_size(f_bus_size), .bus_rnw(f_bus_rnw),
        .bus_wdata(f_bus_wdata), .bus_complete(bus_complete), .bus_rdata(bus_rdata),
        .bus_berr(bus_berr), .dbg_state(f_state)
    );

    // ---------------- monitor mux ----------------
    logic [NCH-1:0] m_done, m_grant;
    logic           m_err, m_busy, m_bus_req, m_bus_rnw;
    logic [DW-1:0]  m_rdata, m_bus_wdata;
    logic [AW-1:0]  m_bus_addr;
    logic [1:0]     m_bus_size, m_state;
    assign m_done      = sel_fp ? f_done      : r_done;
    assign m_grant     = sel_fp ? f_grant     : r_grant;
    assign m_err       = sel_fp ? f_err       : r_err;
    assign m_busy      = sel_fp ? f_busy      : r_busy;
    assign m_bus_req   = sel_fp ? f_bus_req   : r_bus_req;
    assign m_bus_rnw   = sel_fp ? f_bus_rnw   : r_bus_rnw;
    assign m_rdata     = sel_fp ? f_rdata     : r_rdata;
    assign m_bus_wdata = sel_fp ? f_bus_wdata : r_bus_wdata;
    assign m_bus_addr  = sel_fp ? f_bus_addr  : r_bus_addr;
    assign m_bus_size  = sel_fp ? f_bus_size  : r_bus_size;
    assign m_state     = sel_fp ? f_state     : r_state;

    // ---------------- scoreboard ----------------
    int             n_checks = 0;
    int             n_errors = 0;
    logic [NCH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction. The expected grant comes from exp_q. delay is
    // the WAIT cycle (0 = first) in which bus_complete is driven; a negative
    // delay means the controller never answers.
    task automatic run_txn(input string name, input int delay, input logic [DW-1:0] rd,
                           input logic berr, input logic [NCH-1:0] drop);
        logic [NCH-1:0] eg;
        logic [DW-1:0]  e_rdata;
        logic           e_err;
        int             gi, e_lat, wait_n, lat;
        bit             seen, tmo;

        eg = exp_q.pop_front();
        gi = 0;
        for (int i = 0; i < NCH; i++) if (eg[i]) gi = i;
        tmo     = (delay < 0) || (delay > TO - 1);
        e_err   = tmo ? 1'b1 : berr;
        e_rdata = (tmo || !ch_rnw[gi]) ? '0 : rd;
        e_lat   = tmo ? TO + 1 : delay + 2;

        seen   = 0;
        wait_n = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            wait_n++;
            if (m_bus_req) seen = 1;
        end
        check_eq({name, "/bus_req_seen"}, 64'(seen), 64'(1));
        if (!seen) return;
        check_eq({name, "/req_latency"}, 64'(wait_n), 64'(1));
        check_eq({name, "/state_req"}, 64'(m_state), 64'(1));
        check_eq({name, "/grant"}, 64'(m_grant), 64'(eg));
        check_eq({name, "/busy"}, 64'(m_busy), 64'(1));
        check_eq({name, "/bus_addr"}, 64'(m_bus_addr), 64'(ch_addr[gi*AW +: AW]));
        check_eq({name, "/bus_size"}, 64'(m_bus_size), 64'(ch_size[gi*2 +: 2]));
        check_eq({name, "/bus_rnw"}, 64'(m_bus_rnw), 64'(ch_rnw[gi]));
        check_eq({name, "/bus_wdata"}, 64'(m_bus_wdata), 64'(ch_wdata[gi*DW +: DW]));

        seen = 0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            if (i == 0) check_eq({name, "/bus_req_width"}, 64'(m_bus_req), 64'(0));
            if (m_done != '0) begin
                seen = 1;
            end else begin
                bus_complete = (i == delay);
                bus_rdata    = (i == delay) ? rd : DW'($urandom());
                bus_berr     = (i == delay) ? berr : 1'($urandom_range(0, 1));
            end
        end
        bus_complete = 1'b0;
        bus_berr     = 1'b0;
        check_eq({name, "/done_seen"}, 64'(seen), 64'(1));
        if (!seen) return;
        check_eq({name, "/done_latency"}, 64'(lat), 64'(e_lat));
        check_eq({name, "/ch_done"}, 64'(m_done), 64'(eg));
        check_eq({name, "/ch_err"}, 64'(m_err), 64'(e_err));
        check_eq({name, "/ch_rdata"}, 64'(m_rdata), 64'(e_rdata));
        check_eq({name, "/bus_addr_hold"}, 64'(m_bus_addr), 64'(ch_addr[gi*AW +: AW]));

        // requester releases on the edge that ends the done cycle
        req = req & ~drop;
        @(negedge CLK);
        check_eq({name, "/idle_done"}, 64'(m_done), 64'(0));
        check_eq({name, "/idle_grant"}, 64'(m_grant), 64'(0));
        check_eq({name, "/idle_busy"}, 64'(m_busy), 64'(0));
        check_eq({name, "/rdata_hold"}, 64'(m_rdata), 64'(e_rdata));
        check_eq({name, "/err_hold"}, 64'(m_err), 64'(e_err));
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "/state"}, 64'(m_state), 64'(0));
        check_eq({name, "/busy"}, 64'(m_busy), 64'(0));
        check_eq({name, "/grant"}, 64'(m_grant), 64'(0));
        check_eq({name, "/bus_req"}, 64'(m_bus_req), 64'(0));
        check_eq({name, "/ch_done"}, 64'(m_done), 64'(0));
        check_eq({name, "/ch_err"}, 64'(m_err), 64'(0));
        check_eq({name, "/ch_rdata"}, 64'(m_rdata), 64'(0));
        check_eq({name, "/bus_addr"}, 64'(m_bus_addr), 64'(0));
        check_eq({name, "/bus_size"}, 64'(m_bus_size), 64'(0));
        check_eq({name, "/bus_rnw"}, 64'(m_bus_rnw), 64'(1));
        check_eq({name, "/bus_wdata"}, 64'(m_bus_wdata), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        ch_addr[0*AW +: AW]  = 32'h0000_0010;
        ch_addr[1*AW +: AW]  = 32'h2000_0004;
        ch_addr[2*AW +: AW]  = 32'h3000_0008;
        ch_addr[3*AW +: AW]  = 32'h4000_000C;
        ch_size              = {2'b11, 2'b01, 2'b10, 2'b00};
        ch_rnw               = 4'b1101;
        ch_wdata[0*DW +: DW] = 32'hA5A5_0000;
        ch_wdata[1*DW +: DW] = 32'h1234_5678;
        ch_wdata[2*DW +: DW] = 32'hA5A5_0002;
        ch_wdata[3*DW +: DW] = 32'hA5A5_0003;

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        nRESET = 1'b1;
        @(negedge CLK);

        // single read, channel 0, completion in the 3rd cycle after bus_req
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        run_txn("read0", 2, 32'hDEAD_BEEF, 1'b0, 4'b0001);

        // write, channel 1, minimum latency
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        run_txn("write1", 0, 32'hCAFE_F00D, 1'b0, 4'b0010);

        // bus error passthrough, channel 2
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        run_txn("berr2", 1, 32'h55AA_55AA, 1'b1, 4'b0100);

        // watchdog, channel 3, controller silent
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        run_txn("timeout3", -1, 32'h0, 1'b0, 4'b1000);

        // completion in the watchdog's last cycle wins
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        run_txn("tmo_race0", TO - 1, 32'h0BAD_CAFE, 1'b0, 4'b0001);

        // reset in the middle of WAIT, then a stray completion
        req = 4'b0010;
        @(negedge CLK);
        check_eq("rst_mid/bus_req", 64'(m_bus_req), 64'(1));
        @(negedge CLK);
        check_eq("rst_mid/state_wait", 64'(m_state), 64'(2));
        nRESET = 1'b0;
        req    = '0;
        #1;
        check_reset_outputs("rst_mid_async");
        @(negedge CLK);
        nRESET       = 1'b1;
        bus_complete = 1'b1;
        bus_rdata    = 32'hFFFF_0000;
        bus_berr     = 1'b1;
        @(negedge CLK);
        bus_complete = 1'b0;
        bus_berr     = 1'b0;
        check_reset_outputs("rst_mid_stray");

        // round-robin fairness from reset: all requests held
        req = 4'b1111;
        for (int k = 0; k < 8; k++) exp_q.push_back(4'b0001 << (k % 4));
        for (int k = 0; k < 8; k++) begin
            run_txn($sformatf("rr%0d", k), k % 3, 32'h1000_0000 + 32'(k), 1'b0,
                    (k == 7) ? 4'b1111 : 4'b0000);
        end

        // fixed priority on the second instance
        sel_fp = 1'b1;
        req    = 4'b1111;
        exp_q.push_back(4'b0001);
        run_txn("fp_a", 1, 32'h0000_00A1, 1'b0, 4'b0000);
        exp_q.push_back(4'b0001);
        run_txn("fp_b", 0, 32'h0000_00B1, 1'b0, 4'b0001);
        exp_q.push_back(4'b0010);
        run_txn("fp_c", 2, 32'h0000_00C1, 1'b0, 4'b0010);
        exp_q.push_back(4'b0100);
        run_txn("fp_d", 0, 32'h0000_00D1, 1'b1, 4'b0100);
        exp_q.push_back(4'b1000);
        run_txn("fp_e", 3, 32'h0000_00E1, 1'b0, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_req_arbiter.md
Name: bus_req_arbiter

Overview:
- Parametrised N-channel front end for the 68020 bus controller's internal request port (BReq/AddrReq/SizeReq/BReqComplete/Data).
- Successor to the single-requester ICache hookup: any number of requesters (ICache, DCache, prefetch, DMA) share one controller.
- Channels are selected by a round-robin or fixed-priority policy.
- Adds write support, bus-error passthrough and a watchdog timeout for unterminated cycles.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- AW, 32, address width.
- DW, 32, data width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest).
- TIMEOUT, 256, WAIT-state cycles before forced error completion; 0 disables the watchdog.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request level, held until that channel's ch_done.
- ch_addr  in  NUM_CH*AW  per-channel address, channel k at [k*AW +: AW].
- ch_size  in  NUM_CH*2  per-channel size: 00 = long, 01 = byte, 10 = word, 11 = 3-byte.
- ch_rnw  in  NUM_CH  per-channel direction, 1 = read.
- ch_wdata  in  NUM_CH*DW  per-channel write data.
- ch_done  out  NUM_CH  one-cycle completion strobe, one-hot.
- ch_err  out  1  error flag, valid while any ch_done is high.
- ch_rdata  out  DW  read data, valid while any ch_done is high.
- grant  out  NUM_CH  one-hot owner of the current transaction, 0 when idle.
- busy  out  1  high in every state except IDLE.
- bus_req  out  1  one-cycle request pulse to the bus controller.
- bus_addr  out  AW  latched address.
- bus_size  out  2  latched size.
- bus_rnw  out  1  latched direction.
- bus_wdata  out  DW  latched write data.
- bus_complete  in  1  controller completion (level or pulse).
- bus_rdata  in  DW  controller read data, sampled with bus_complete.
- bus_berr  in  1  controller bus error, sampled with bus_complete.

Behaviour:
- Reset: state = IDLE; all outputs 0, except bus_rnw = 1 and the round-robin pointer = NUM_CH-1 (so channel 0 wins first).
- FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If ch_req != 0, select the winner per policy.
  - Latch the winner's addr/size/rnw/wdata into the bus_* registers and set grant one-hot.
  - Go to REQ on the same edge.
- Round-robin policy: search from (ptr+1) mod NUM_CH upward with wrap. ptr updates to the winner at grant time.
- Fixed-priority policy: lowest asserted index wins; ptr is unused.
- REQ:
  - bus_req = 1 for exactly this one cycle.
  - Watchdog counter cleared.
  - Go to WAIT unconditionally. bus_complete is ignored in REQ.
- WAIT:
  - On bus_complete, capture bus_rdata into ch_rdata (zeroed if bus_rnw = 0) and bus_berr into ch_err, then go to RESP.
  - Otherwise the counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no completion: ch_err = 1, ch_rdata = 0, go to RESP.
  - Completion wins over timeout when both occur in the same cycle.
- RESP:
  - ch_done[i] = 1 for one cycle, where grant[i] = 1.
  - ch_rdata and ch_err hold their values.
  - Next state is IDLE. Exiting RESP clears grant and ch_done; ch_rdata and ch_err hold until the next RESP.
- Requester rule: drop ch_req on the edge that ends its RESP cycle. IDLE then sees it low, so there is no double service.
- Minimum latency: ch_req sampled at edge 0 → bus_req high cycle 1 → bus_complete in cycle 2 → ch_done high cycle 3.
- Throughput: one transaction per 4 cycles minimum. IDLE is always visited for 1 cycle.
- Reset asserted mid-transaction: immediate return to IDLE with outputs at reset values. A late bus_complete arriving in IDLE/REQ is ignored.
- Requests that appear or vanish while not in IDLE do not affect the current transaction. The bus_* latches are stable from REQ through RESP.
- NUM_CH = 1: arbiter degenerates to a pass-through with the same timing.

Test Plan:
- Single read: NUM_CH = 2, ch_req = 01, addr0 = 0x00000010, rnw = 1; bus_complete in 3rd cycle after bus_req, bus_rdata = 0xDEADBEEF → exactly one bus_req pulse with bus_addr = 0x10; ch_done = 01; ch_rdata = 0xDEADBEEF; ch_err = 0.
- Round-robin fairness: NUM_CH = 4, all ch_req held high and re-raised immediately after each done, 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Fixed priority: same stimulus with RR_MODE = 0 → channel 0 served every time; channel 3 is served only after channels 0 through 2 drop their requests.
- Error and timeout:
  - bus_berr = 1 with completion → ch_err = 1 alongside ch_done.
  - TIMEOUT = 16 with no bus_complete → ch_done with ch_err = 1 and ch_rdata = 0 exactly 16 cycles after entering WAIT.
  - Completion and timeout in the same cycle → completion data is taken.
- Write: ch_rnw = 0, ch_wdata = 0x12345678, size = 10 → bus_wdata = 0x12345678, bus_size = 10, bus_rnw = 0; ch_rdata = 0 on done.
- Reset mid-WAIT: nRESET low for 1 cycle, then a stray bus_complete → all outputs at reset values, no ch_done, busy = 0.
